sd_blk_arbiter: RTL
===================

Name: sd_blk_arbiter

Overview:
- Shares one hps_io virtual-drive block channel (sd_rd/sd_wr/sd_lba/sd_ack/sd_buff_*) between NREQ block requesters: HDD controller and floppy_track loaders.
- Latches read/write requests, grants round-robin and drives the hps_io handshake.
- Routes buffer strobes and read data to the granted requester and holds each requester's wait line until its transfer ends.
- Sits in emu between hps_io and the storage front-ends; replaces the ad-hoc HDD pending/ack logic.

Parameters:
- NREQ, 3, number of requesters (2..4)
- LBA_W, 32, sector address width
- TO_CYC, 24'd14_000_000, watchdog limit in clk_sys cycles (used only with the optional feature)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_rd  in  NREQ  per-requester read-request pulse
- req_wr  in  NREQ  per-requester write-request pulse
- req_lba  in  NREQ*LBA_W  per-requester sector, packed, requester i at [i*LBA_W +: LBA_W]
- req_buff_din  in  NREQ*8  per-requester write data, packed
- req_wait  out  NREQ  requester i has a pending or active transfer
- req_done  out  NREQ  one-cycle completion pulse
- req_buff_wr  out  NREQ  sd_buff_wr routed to the granted requester
- sd_rd  out  1  to hps_io
- sd_wr  out  1  to hps_io
- sd_lba  out  LBA_W  to hps_io
- sd_ack  in  1  from hps_io
- sd_buff_wr  in  1  from hps_io
- sd_buff_din  out  8  req_buff_din of the granted requester
- grant  out  2  index of the current or last grant
- timeout  out  1  sticky watchdog flag (0 when feature absent)

Behaviour:
- Reset (async, reset_n=0): state IDLE, all pending cleared, rr pointer=0, grant=0. sd_rd, sd_wr, req_wait, req_done, req_buff_wr, timeout all 0; sd_lba=0.
- Pending latches:
  - pend_rd[i] |= req_rd[i]; pend_wr[i] |= req_wr[i], every cycle.
  - req_wait[i] = pend_rd[i] | pend_wr[i] | (active & grant==i), registered; rises the cycle after the request pulse.
- Arbitration (IDLE): search from rr pointer upward with wrap. The first i with any pending bit wins.
  - grant<=i; sd_lba<=req_lba[i], captured once and held.
  - If pend_wr[i]: sd_wr<=1 and clear pend_wr[i]. Else: sd_rd<=1 and clear pend_rd[i]. Write precedes read for the same requester.
  - A request pulse arriving in the same cycle as its clear re-sets pending (set wins).
  - rr pointer<=i+1 mod NREQ. Go to REQ.
- REQ: hold sd_rd/sd_wr until sd_ack rises (edge detected on a registered copy). On the rise, drop sd_rd/sd_wr and go to XFER.
- XFER:
  - req_buff_wr[grant]=sd_buff_wr & sd_ack, combinational; all other requesters get 0.
  - sd_buff_din=req_buff_din[grant], combinational in all states.
  - On sd_ack falling: req_done[grant] pulses one cycle, then go to IDLE. If nothing else is pending for that requester, req_wait[grant] clears the same cycle.
- Minimum latency IDLE→sd_rd: 1 cycle after the pending bit. Back-to-back grants need one IDLE cycle between them.
- sd_ack already high on entry to REQ: wait for it to fall, then rise (edge required).
- grant index ≥ NREQ is never produced.
- The packing rules above are the only width rules; no arithmetic beyond the rr pointer wrap.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- With the macro:
  - A 24-bit counter runs in REQ/XFER and clears on each state entry.
  - On reaching TO_CYC: drop sd_rd/sd_wr, pulse req_done[grant], set sticky timeout, return to IDLE.
  - timeout clears only on reset.
- Without the macro: no counter; timeout tied 0; the FSM waits indefinitely.

Decomposition:
- Package sd_arb_pkg:
  - state enum {IDLE, REQ, XFER}
  - constant TO_W=24
  - function rr_pick(pending, ptr) returning a valid bit and an index.
- Single module plus one natural sub-module, sd_arb_rr, a combinational round-robin picker (pending vector + pointer → index/valid). Everything sequential stays in sd_blk_arbiter.

Test Plan:
- Single HDD read: req_rd[0] pulse, req_lba[0]=0x1234 → sd_rd=1 with sd_lba=0x1234 next cycle. ack high 3 cycles later → sd_rd=0. 512 sd_buff_wr → 512 req_buff_wr[0] pulses. ack low → req_done[0] one cycle, req_wait[0]=0.
- Simultaneous req_rd[0], req_rd[1], req_rd[2] at reset pointer 0 → grants in order 0,1,2. A new req_rd[0] during grant 2 is served after 2.
- Same requester pulses req_rd[1] and req_wr[1] together → write transfer first (sd_wr), then read (sd_rd); req_wait[1] stays high throughout.
- reset_n low mid-XFER → all outputs 0 immediately, no req_done. After release, a fresh req_rd[2] → grant=2 with no stale pending.
- sd_ack already high when the grant is issued → no XFER until ack falls then rises again.
- With SD_ARB_TIMEOUT_EN, TO_CYC=100, no ack → at cycle 100 sd_rd drops, req_done pulses, timeout=1 and stays 1 until reset.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD block-channel arbiter.
// Holds the FSM state type, the watchdog counter width and the
// round-robin pick function used by sd_arb_rr.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam int TO_W    = 24;
  localparam int MAX_REQ = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } rr_pick_t;

  // Search upward from ptr with wrap at nreq; first pending bit wins.
  // Candidates never reach nreq, so the index is always a real requester.
  function automatic rr_pick_t rr_pick(input logic [3:0] pending,
                                       input logic [1:0] ptr,
                                       input logic [2:0] nreq);
    rr_pick_t   res;
    logic [2:0] cand;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = {1'b0, ptr} + 3'(k);
      if (cand >= nreq) begin
        cand = cand - nreq;
      end else begin
        cand = cand;
      end
      if ((3'(k) < nreq) && !res.valid && pending[cand[1:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sd_arb_rr.sv
// Combinational round-robin picker: pending vector + start pointer
// in, winning requester index and valid flag out.
module sd_arb_rr
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] pend_i,
  input  logic [1:0]      ptr_i,
  output logic            valid_o,
  output logic [1:0]      idx_o
);

  logic [3:0] pend_ext_s;
  rr_pick_t   pick_s;

  // Widen the pending vector to the picker's fixed width and search it.
  always_comb begin
    pend_ext_s             = 4'b0000;
    pend_ext_s[NREQ-1:0]   = pend_i;
    pick_s                 = rr_pick(pend_ext_s, ptr_i, 3'(NREQ));
  end

  assign valid_o = pick_s.valid;
  assign idx_o   = pick_s.idx;

endmodule

// File: rtl/sd_blk_arbiter.sv
// Shares one hps_io virtual-drive block channel between NREQ requesters.
// Latches read/write request pulses, grants round-robin (write before read
// for the same requester), drives sd_rd/sd_wr until sd_ack rises, routes
// buffer strobes/data during the transfer and pulses req_done on ack fall.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort REQ/XFER after TO_CYC
// cycles and raise a sticky timeout flag; otherwise timeout stays 0.
module sd_blk_arbiter
  import sd_arb_pkg::*;
#(
  parameter int              NREQ   = 3,
  parameter int              LBA_W  = 32,
  parameter logic [TO_W-1:0] TO_CYC = 24'd14_000_000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*LBA_W-1:0] req_lba,
  input  logic [NREQ*8-1:0]     req_buff_din,
  output logic [NREQ-1:0]       req_wait,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       req_buff_wr,
  output logic                  sd_rd,
  output logic                  sd_wr,
  output logic [LBA_W-1:0]      sd_lba,
  input  logic                  sd_ack,
  input  logic                  sd_buff_wr,
  output logic [7:0]            sd_buff_din,
  output logic [1:0]            grant,
  output logic                  timeout
);

  localparam logic [1:0] LAST_IDX = 2'(NREQ - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [NREQ-1:0]   clr_rd_s, clr_wr_s;
  logic [NREQ-1:0]   wait_q, wait_d, done_q, done_d;
  logic [1:0]        ptr_q, ptr_d, grant_q, grant_d;
  logic              sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [LBA_W-1:0]  lba_q, lba_d;
  logic              ack_q;
  logic              ack_rise_s, ack_fall_s;
  logic              pick_valid_s;
  logic [1:0]        pick_idx_s;
  logic              to_hit_s;
  logic              timeout_q, timeout_d;
  logic [NREQ-1:0]   req_buff_wr_s;

  sd_arb_rr #(.NREQ(NREQ)) u_rr (
    .pend_i  (pend_rd_q | pend_wr_q),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  // Edges are taken against a registered copy so an ack already high at
  // grant time must fall and rise again before the transfer starts.
  assign ack_rise_s = sd_ack & ~ack_q;
  assign ack_fall_s = ~sd_ack & ack_q;

`ifdef SD_ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;

  assign to_hit_s = (state_q != IDLE) && ((cnt_q + TO_W'(1)) == TO_CYC);

  // Watchdog counter: restarts on every state entry, counts in REQ/XFER.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + TO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_to_s;
  assign unused_to_s = ^TO_CYC;
  assign to_hit_s    = 1'b0;
`endif

  // Next-state, grant capture, pending bookkeeping and wait/done generation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    lba_d     = lba_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    done_d    = '0;
    timeout_d = timeout_q;
    clr_rd_s  = '0;
    clr_wr_s  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          grant_d = pick_idx_s;
          lba_d   = req_lba[pick_idx_s*LBA_W +: LBA_W];
          if (pend_wr_q[pick_idx_s]) begin
            sd_wr_d              = 1'b1;
            clr_wr_s[pick_idx_s] = 1'b1;
          end else begin
            sd_rd_d              = 1'b1;
            clr_rd_s[pick_idx_s] = 1'b1;
          end
          ptr_d   = (pick_idx_s == LAST_IDX) ? 2'd0 : pick_idx_s + 2'd1;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ack_rise_s) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
        end else if (to_hit_s) begin
          sd_rd_d           = 1'b0;
          sd_wr_d           = 1'b0;
          done_d[grant_q]   = 1'b1;
          timeout_d         = 1'b1;
          state_d           = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      XFER: begin
        if (ack_fall_s) begin
          done_d[grant_q] = 1'b1;
          state_d         = IDLE;
        end else if (to_hit_s) begin
          sd_rd_d         = 1'b0;
          sd_wr_d         = 1'b0;
          done_d[grant_q] = 1'b1;
          timeout_d       = 1'b1;
          state_d         = IDLE;
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // A request pulse in the same cycle as its clear keeps the bit set.
    pend_rd_d = (pend_rd_q & ~clr_rd_s) | req_rd;
    pend_wr_d = (pend_wr_q & ~clr_wr_s) | req_wr;
    for (int i = 0; i < NREQ; i++) begin
      wait_d[i] = pend_rd_d[i] | pend_wr_d[i] |
                  ((state_d != IDLE) && (grant_d == 2'(i)));
    end
  end

  // Strobe and data routing to/from the granted requester.
  always_comb begin
    req_buff_wr_s = '0;
    if (state_q == XFER) begin
      req_buff_wr_s[grant_q] = sd_buff_wr & sd_ack;
    end else begin
      req_buff_wr_s = '0;
    end
  end

  assign sd_buff_din = req_buff_din[grant_q*8 +: 8];

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
      wait_q    <= '0;
      done_q    <= '0;
      ptr_q     <= 2'd0;
      grant_q   <= 2'd0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      lba_q     <= '0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      lba_q     <= lba_d;
      ack_q     <= sd_ack;
      timeout_q <= timeout_d;
    end
  end

  assign req_wait    = wait_q;
  assign req_done    = done_q;
  assign req_buff_wr = req_buff_wr_s;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = lba_q;
  assign grant       = grant_q;
  assign timeout     = timeout_q;

endmodule
